usb_pkt_decoder: RTL and testbench

//  Receive-side packet decoder, directly downstream of the USB low/full-speed receiver. Consumes

---
 rtl/usb_pkt_decoder.sv | 255 +++++++++++++++++++++++++
 tb/tb_usb_pkt_decoder.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_pkt_decoder.sv
// Receive-side USB LS/FS packet decoder: PID check, token/SOF field decode, CRC5/CRC16 check,
// data payload forwarding with the trailing CRC16 held back by a 2-byte delay line.
module usb_pkt_decoder #(
  parameter int unsigned MAX_PAYLOAD = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  input  logic        rx_active_i,
  input  logic        rx_error_i,
  output logic [3:0]  pid_o,
  output logic        tok_valid_o,
  output logic [6:0]  tok_addr_o,
  output logic [3:0]  tok_endp_o,
  output logic        sof_valid_o,
  output logic [10:0] sof_frame_o,
  output logic [7:0]  dat_data_o,
  output logic        dat_valid_o,
  output logic        hsk_valid_o,
  output logic        pkt_end_o,
  output logic        pkt_ok_o,
  output logic        pid_err_o,
  output logic        crc_err_o,
  output logic        len_err_o
);

  localparam int unsigned     CntW   = $clog2(MAX_PAYLOAD + 3) + 1;
  localparam logic [CntW-1:0] CntTwo = CntW'(2);
  localparam logic [CntW-1:0] CntLen = CntW'(MAX_PAYLOAD + 2);

  typedef enum logic [2:0] {
    StIdle, StPid, StTok1, StTok2, StTend, StData, StHsk, StDrain
  } state_e;

  state_e          state_q, state_d, pid_st, st_after;
  logic            act_q, pid_good;
  logic [4:0]      crc5_q, crc5_d;
  logic [15:0]     crc16_q, crc16_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      b0_q, b0_d, b1_q, b1_d, d0_q, d0_d, d1_q, d1_d;
  logic [3:0]      pid_q, pid_d;
  logic            pid_err_q, pid_err_d, crc_err_q, crc_err_d, len_err_q, len_err_d;
  logic [6:0]      tok_addr_q, tok_addr_d;
  logic [3:0]      tok_endp_q, tok_endp_d;
  logic [10:0]     sof_frame_q, sof_frame_d;
  logic [7:0]      dat_data_q, dat_data_d;
  logic            dat_valid_q, dat_valid_d, tok_valid_q, tok_valid_d;
  logic            sof_valid_q, sof_valid_d, hsk_valid_q, hsk_valid_d;
  logic            pkt_end_q, pkt_end_d, pkt_ok_q, pkt_ok_d;

  function automatic logic [4:0] crc5_byte(input logic [4:0] crc, input logic [7:0] d);
    logic [4:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      c = {c[3:0], 1'b0} ^ ((c[4] ^ d[i]) ? 5'h05 : 5'h00);
    end
    return c;
  endfunction

  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] d);
    logic [15:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      c = {c[14:0], 1'b0} ^ ((c[15] ^ d[i]) ? 16'h8005 : 16'h0000);
    end
    return c;
  endfunction

  always_comb begin
    state_d     = state_q;
    crc5_d      = crc5_q;
    crc16_d     = crc16_q;
    cnt_d       = cnt_q;
    b0_d        = b0_q;
    b1_d        = b1_q;
    d0_d        = d0_q;
    d1_d        = d1_q;
    pid_d       = pid_q;
    pid_err_d   = pid_err_q;
    crc_err_d   = crc_err_q;
    len_err_d   = len_err_q;
    tok_addr_d  = tok_addr_q;
    tok_endp_d  = tok_endp_q;
    sof_frame_d = sof_frame_q;
    dat_data_d  = dat_data_q;
    dat_valid_d = 1'b0;
    tok_valid_d = 1'b0;
    sof_valid_d = 1'b0;
    hsk_valid_d = 1'b0;
    pkt_end_d   = 1'b0;
    pkt_ok_d    = 1'b0;
    st_after    = StIdle;

    unique case (rx_data_i[3:0])
      4'h1, 4'h5, 4'h9, 4'hD: pid_st = StTok1;
      4'h3, 4'hB:             pid_st = StData;
      4'h2, 4'hA, 4'hE:       pid_st = StHsk;
      default:                pid_st = StDrain;
    endcase
    pid_good = (rx_data_i[7:4] == ~rx_data_i[3:0]) && (pid_st != StDrain);

    if (state_q == StIdle) begin
      if (rx_active_i && !act_q) begin
        state_d   = StPid;
        pid_err_d = 1'b0;
        crc_err_d = 1'b0;
        len_err_d = 1'b0;
        crc5_d    = '1;
        crc16_d   = '1;
        cnt_d     = '0;
      end
    end else begin
      if (rx_error_i) begin
        state_d   = StDrain;
        len_err_d = 1'b1;
      end else if (rx_valid_i) begin
        unique case (state_q)
          StPid: begin
            if (pid_good) begin
              pid_d   = rx_data_i[3:0];
              state_d = pid_st;
            end else begin
              pid_err_d = 1'b1;
              state_d   = StDrain;
            end
          end
          StTok1: begin
            b0_d    = rx_data_i;
            crc5_d  = crc5_byte(crc5_q, rx_data_i);
            state_d = StTok2;
          end
          StTok2: begin
            b1_d    = rx_data_i;
            crc5_d  = crc5_byte(crc5_q, rx_data_i);
            state_d = StTend;
          end
          StTend, StHsk: begin
            state_d   = StDrain;
            len_err_d = 1'b1;
          end
          StData: begin
            crc16_d = crc16_byte(crc16_q, rx_data_i);
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
            // Byte N leaves the delay line only once byte N+2 shows it is not CRC.
            if (cnt_q >= CntLen) begin
              len_err_d = 1'b1;
            end else if (cnt_q >= CntTwo) begin
              dat_valid_d = 1'b1;
              dat_data_d  = d0_q;
            end
            d0_d = d1_q;
            d1_d = rx_data_i;
          end
          default: ;
        endcase
      end

      if (!rx_active_i) begin
        st_after  = state_d;
        state_d   = StIdle;
        pkt_end_d = 1'b1;
        unique case (st_after)
          StPid, StTok1, StTok2: len_err_d = 1'b1;
          StTend: if (crc5_d != 5'b01100) crc_err_d = 1'b1;
          StData: begin
            if (cnt_d < CntTwo) len_err_d = 1'b1;
            else if (crc16_d != 16'h800D) crc_err_d = 1'b1;
          end
          default: ;
        endcase
        pkt_ok_d = !(pid_err_d || crc_err_d || len_err_d);
        if (pkt_ok_d) begin
          if (st_after == StTend && pid_d == 4'h5) begin
            sof_valid_d = 1'b1;
            sof_frame_d = {b1_d[2:0], b0_d};
          end else if (st_after == StTend) begin
            tok_valid_d = 1'b1;
            tok_addr_d  = b0_d[6:0];
            tok_endp_d  = {b1_d[2:0], b0_d[7]};
          end
          hsk_valid_d = (st_after == StHsk);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      act_q       <= 1'b1;  // a packet already in flight at reset release is not a rise
      crc5_q      <= '1;
      crc16_q     <= '1;
      cnt_q       <= '0;
      b0_q        <= '0;
      b1_q        <= '0;
      d0_q        <= '0;
      d1_q        <= '0;
      pid_q       <= '0;
      pid_err_q   <= 1'b0;
      crc_err_q   <= 1'b0;
      len_err_q   <= 1'b0;
      tok_addr_q  <= '0;
      tok_endp_q  <= '0;
      sof_frame_q <= '0;
      dat_data_q  <= '0;
      dat_valid_q <= 1'b0;
      tok_valid_q <= 1'b0;
      sof_valid_q <= 1'b0;
      hsk_valid_q <= 1'b0;
      pkt_end_q   <= 1'b0;
      pkt_ok_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      act_q       <= rx_active_i;
      crc5_q      <= crc5_d;
      crc16_q     <= crc16_d;
      cnt_q       <= cnt_d;
      b0_q        <= b0_d;
      b1_q        <= b1_d;
      d0_q        <= d0_d;
      d1_q        <= d1_d;
      pid_q       <= pid_d;
      pid_err_q   <= pid_err_d;
      crc_err_q   <= crc_err_d;
      len_err_q   <= len_err_d;
      tok_addr_q  <= tok_addr_d;
      tok_endp_q  <= tok_endp_d;
      sof_frame_q <= sof_frame_d;
      dat_data_q  <= dat_data_d;
      dat_valid_q <= dat_valid_d;
      tok_valid_q <= tok_valid_d;
      sof_valid_q <= sof_valid_d;
      hsk_valid_q <= hsk_valid_d;
      pkt_end_q   <= pkt_end_d;
      pkt_ok_q    <= pkt_ok_d;
    end
  end

  assign pid_o       = pid_q;
  assign tok_valid_o = tok_valid_q;
  assign tok_addr_o  = tok_addr_q;
  assign tok_endp_o  = tok_endp_q;
  assign sof_valid_o = sof_valid_q;
  assign sof_frame_o = sof_frame_q;
  assign dat_data_o  = dat_data_q;
  assign dat_valid_o = dat_valid_q;
  assign hsk_valid_o = hsk_valid_q;
  assign pkt_end_o   = pkt_end_q;
  assign pkt_ok_o    = pkt_ok_q;
  assign pid_err_o   = pid_err_q;
  assign crc_err_o   = crc_err_q;
  assign len_err_o   = len_err_q;

endmodule

// File: tb/tb_usb_pkt_decoder.sv
// Scoreboard bench for usb_pkt_decoder: a packet-level reference model pushes expected payload
// bytes and end-of-packet status; a monitor pops and compares whenever the DUT presents them.
module tb_usb_pkt_decoder;

  localparam int MAX = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_active, rx_error;
  logic [3:0]  pid;
  logic        tok_valid, sof_valid, dat_valid, hsk_valid, pkt_end, pkt_ok;
  logic [6:0]  tok_addr;
  logic [3:0]  tok_endp;
  logic [10:0] sof_frame;
  logic [7:0]  dat_data;
  logic        pid_err, crc_err, len_err;

  usb_pkt_decoder #(.MAX_PAYLOAD(MAX)) dut (
    .clk(clk), .reset(reset), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .rx_active_i(rx_active), .rx_error_i(rx_error), .pid_o(pid), .tok_valid_o(tok_valid),
    .tok_addr_o(tok_addr), .tok_endp_o(tok_endp), .sof_valid_o(sof_valid),
    .sof_frame_o(sof_frame), .dat_data_o(dat_data), .dat_valid_o(dat_valid),
    .hsk_valid_o(hsk_valid), .pkt_end_o(pkt_end), .pkt_ok_o(pkt_ok), .pid_err_o(pid_err),
    .crc_err_o(crc_err), .len_err_o(len_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ok, pid_err, crc_err, len_err, tok_v, sof_v, hsk_v;
    logic [3:0]  pid;
    logic [6:0]  addr;
    logic [3:0]  endp;
    logic [10:0] frame;
  } exp_t;

  exp_t        pkt_q[$];
  logic [7:0]  dat_q[$];
  int          n_checks = 0;
  int          n_err = 0;
  logic [3:0]  m_pid = '0;
  logic [6:0]  m_addr = '0;
  logic [3:0]  m_endp = '0;
  logic [10:0] m_frame = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference CRCs: message bits LSB-first; field sent as complement, MSB of remainder first.
  function automatic logic [4:0] crc5_of(input logic [10:0] v);
    logic [4:0] c;
    c = 5'h1F;
    for (int i = 0; i < 11; i++) c = {c[3:0], 1'b0} ^ ((c[4] ^ v[i]) ? 5'h05 : 5'h00);
    return c;
  endfunction

  function automatic logic [7:0] tok_b2(input logic [10:0] v);
    logic [4:0] c;
    logic [7:0] r;
    c = crc5_of(v);
    r = {5'b0, v[10:8]};
    for (int k = 0; k < 5; k++) r[3+k] = ~c[4-k];
    return r;
  endfunction

  function automatic logic [15:0] crc16_add(input logic [15:0] crc, input logic [7:0] d);
    logic [15:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) c = {c[14:0], 1'b0} ^ ((c[15] ^ d[i]) ? 16'h8005 : 16'h0000);
    return c;
  endfunction

  function automatic logic [15:0] crc16_field(input logic [15:0] c);
    logic [15:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i]   = ~c[15-i];
      r[8+i] = ~c[7-i];
    end
    return r;
  endfunction

  // Packet-level model: bytes b (PID first); rx_error replaces byte err_at (-1: none).
  task automatic model_pkt(input logic [7:0] b[$], input int err_at);
    exp_t        e;
    int          m, n, ne;
    bit          err, good, tok, dat, hsk;
    logic [3:0]  p;
    logic [15:0] c;
    tok = 0; dat = 0; hsk = 0; p = '0;
    err = (err_at >= 0);
    m = err ? err_at : b.size();
    e = '0;
    e.len_err = err || (m == 0);
    if (m > 0) begin
      p = b[0][3:0];
      tok = p inside {4'h1, 4'h5, 4'h9, 4'hD};
      dat = p inside {4'h3, 4'hB};
      hsk = p inside {4'h2, 4'hA, 4'hE};
      good = (b[0][7:4] == ~p) && (tok || dat || hsk);
      n = m - 1;
      if (!good) begin
        e.pid_err = 1'b1;
      end else begin
        m_pid = p;
        if (tok) begin
          if (n != 2) e.len_err = 1'b1;
          else if (!err && b[2] != tok_b2({b[2][2:0], b[1]})) e.crc_err = 1'b1;
        end else if (hsk) begin
          if (n != 0) e.len_err = 1'b1;
        end else begin
          if (n < 2 || n > MAX + 2) e.len_err = 1'b1;
          if (n >= 2) begin
            if (!err) begin
              c = 16'hFFFF;
              for (int i = 1; i <= n - 2; i++) c = crc16_add(c, b[i]);
              if ({b[n], b[n-1]} != crc16_field(c)) e.crc_err = 1'b1;
            end
            ne = (n - 2 > MAX) ? MAX : n - 2;
            for (int i = 0; i < ne; i++) dat_q.push_back(b[1+i]);
          end
        end
      end
    end
    e.ok = !(e.pid_err || e.crc_err || e.len_err);
    if (e.ok && tok && p == 4'h5) begin
      e.sof_v = 1'b1;
      m_frame = {b[2][2:0], b[1]};
    end else if (e.ok && tok) begin
      e.tok_v = 1'b1;
      m_addr  = b[1][6:0];
      m_endp  = {b[2][2:0], b[1][7]};
    end
    e.hsk_v = e.ok && hsk;
    e.pid   = m_pid;
    e.addr  = m_addr;
    e.endp  = m_endp;
    e.frame = m_frame;
    pkt_q.push_back(e);
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard queues.
  exp_t       e_mon;
  logic [7:0] d_mon;
  always @(negedge clk) begin
    if (!reset) begin
      if (dat_valid) begin
        if (dat_q.size() == 0) begin
          n_checks++; n_err++;
          $display("FAIL dat_valid: unexpected byte %0h, expected none", dat_data);
        end else begin
          d_mon = dat_q.pop_front();
          check("dat_data", 64'(dat_data), 64'(d_mon));
        end
      end
      if (pkt_end) begin
        if (pkt_q.size() == 0) begin
          n_checks++; n_err++;
          $display("FAIL pkt_end: unexpected pulse, expected none");
        end else begin
          e_mon = pkt_q.pop_front();
          check("pkt_ok",    64'(pkt_ok),    64'(e_mon.ok));
          check("pid_err",   64'(pid_err),   64'(e_mon.pid_err));
          check("crc_err",   64'(crc_err),   64'(e_mon.crc_err));
          check("len_err",   64'(len_err),   64'(e_mon.len_err));
          check("tok_valid", 64'(tok_valid), 64'(e_mon.tok_v));
          check("sof_valid", 64'(sof_valid), 64'(e_mon.sof_v));
          check("hsk_valid", 64'(hsk_valid), 64'(e_mon.hsk_v));
          check("pid",       64'(pid),       64'(e_mon.pid));
          check("tok_addr",  64'(tok_addr),  64'(e_mon.addr));
          check("tok_endp",  64'(tok_endp),  64'(e_mon.endp));
          check("sof_frame", 64'(sof_frame), 64'(e_mon.frame));
        end
      end else if (tok_valid || sof_valid || hsk_valid) begin
        n_checks++; n_err++;
        $display("FAIL stray pulse: tok/sof/hsk=%b%b%b without pkt_end, expected 000",
                 tok_valid, sof_valid, hsk_valid);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b[$], input int err_at, input bit sim_end);
    model_pkt(b, err_at);
    rx_active = 1'b1;
    tick(); tick();
    for (int i = 0; i < b.size(); i++) begin
      if (i == err_at) begin
        rx_error = 1'b1;
        tick();
        rx_error = 1'b0;
        break;
      end
      rx_data  = b[i];
      rx_valid = 1'b1;
      if (sim_end && i == b.size() - 1) rx_active = 1'b0;
      tick();
      rx_valid = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
    end
    rx_active = 1'b0;
    repeat (3) tick();
  endtask

  task automatic send_byte(input logic [7:0] d);
    rx_data  = d;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    tick();
  endtask

  task automatic check_zero(input string name);
    check(name, {pid, tok_valid, tok_addr, tok_endp, sof_valid, sof_frame, dat_data, dat_valid,
                 hsk_valid, pkt_end, pkt_ok, pid_err, crc_err, len_err}, 64'd0);
  endtask

  task automatic rand_pkt();
    logic [7:0]  b[$];
    logic [3:0]  p;
    logic [10:0] v;
    logic [15:0] c;
    int          kind, len, err_at, k;
    b = {};
    err_at = -1;
    kind = $urandom_range(0, 5);
    case (kind)
      0: begin
        k = $urandom_range(0, 3);
        p = (k == 0) ? 4'h1 : (k == 1) ? 4'h9 : (k == 2) ? 4'hD : 4'h5;
        v = 11'($urandom());
        b.push_back({~p, p});
        b.push_back(v[7:0]);
        b.push_back(tok_b2(v));
      end
      1, 2: begin
        p = (kind == 1) ? 4'h3 : 4'hB;
        b.push_back({~p, p});
        len = $urandom_range(0, MAX + 1);
        c = 16'hFFFF;
        for (int i = 0; i < len; i++) begin
          b.push_back(8'($urandom()));
          c = crc16_add(c, b[b.size()-1]);
        end
        c = crc16_field(c);
        b.push_back(c[7:0]);
        b.push_back(c[15:8]);
      end
      3: begin
        k = $urandom_range(0, 2);
        p = (k == 0) ? 4'h2 : (k == 1) ? 4'hA : 4'hE;
        b.push_back({~p, p});
      end
      4: begin
        k = $urandom_range(0, 3);
        p = (k == 0) ? 4'h4 : (k == 1) ? 4'h6 : (k == 2) ? 4'hC : 4'h0;
        if ($urandom_range(0, 1) == 0) b.push_back({~p, p});
        else b.push_back({~p ^ 4'h1, p});
      end
      default: begin
        len = $urandom_range(0, 4);
        for (int i = 0; i < len; i++) b.push_back(8'($urandom()));
      end
    endcase
    if (b.size() > 1 && $urandom_range(0, 4) == 0) begin
      k = $urandom_range(1, b.size() - 1);
      b[k] = b[k] ^ (8'h01 << $urandom_range(0, 7));
    end
    k = $urandom_range(0, 9);
    if (k == 0) b.push_back(8'($urandom()));
    else if (k == 1 && b.size() > 0) void'(b.pop_back());
    if (b.size() > 0 && $urandom_range(0, 9) == 0) err_at = $urandom_range(0, b.size() - 1);
    send(b, err_at, 1'($urandom_range(0, 1)));
  endtask

  initial begin
    reset = 1'b1; rx_data = '0; rx_valid = 1'b0; rx_active = 1'b0; rx_error = 1'b0;
    repeat (3) tick();
    check_zero("reset outputs");
    reset = 1'b0;
    tick();

    send('{8'h2D, 8'h00, 8'h10}, -1, 1'b0);
    send('{8'h2D, 8'h00, 8'h11}, -1, 1'b0);
    send('{8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h94}, -1, 1'b0);
    send('{8'h4B, 8'h00, 8'h00}, -1, 1'b1);
    send('{8'hD2}, -1, 1'b0);
    send('{8'h2C}, -1, 1'b0);
    send('{8'hD2, 8'h00}, -1, 1'b0);
    send('{8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h94}, 5, 1'b0);
    send('{8'hA5, 8'h34, 8'h12}, -1, 1'b0);

    for (int i = 0; i < 300; i++) rand_pkt();

    // Reset lands mid-payload; the rest of the packet must be ignored.
    rx_active = 1'b1;
    tick(); tick();
    send_byte(8'hC3);
    send_byte(8'h80);
    send_byte(8'h06);
    reset = 1'b1;
    m_pid = '0; m_addr = '0; m_endp = '0; m_frame = '0;
    rx_data = 8'h00; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    tick();
    check_zero("mid-packet reset outputs");
    reset = 1'b0;
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h00);
    rx_active = 1'b0;
    repeat (3) tick();
    check_zero("ignored tail after reset");
    send('{8'h2D, 8'h00, 8'h10}, -1, 1'b0);
    send('{8'hE1, 8'h85, 8'h28}, -1, 1'b0);

    repeat (10) tick();
    check("leftover payload", 64'(dat_q.size()), 64'd0);
    check("leftover packets", 64'(pkt_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
